// File: rtl/controller_poller_pkg.sv
// Shared definitions for the NES-style controller poller: FSM state
// encodings, the layout of the CPU-visible controller_data word and the
// commit arithmetic that builds a new word from a finished poll.
package controller_poller_pkg;

   // FSM state encodings, kept as plain constants so legacy decode logic
   // and software-side tooling can use the same numeric values.
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_LATCH    = 3'd1;
   localparam logic [2:0] ST_SETTLE   = 3'd2;
   localparam logic [2:0] ST_PULSE_HI = 3'd3;
   localparam logic [2:0] ST_PULSE_LO = 3'd4;
   localparam logic [2:0] ST_COMMIT   = 3'd5;

   // Bit-field layout of controller_data as seen by the CPU.
   // [7:0] pressed, [15:8] newly pressed, [23:16] poll count, [31:24] zero.
   typedef struct packed {
      logic [7:0] rsvd;
      logic [7:0] seq;
      logic [7:0] newly;
      logic [7:0] pressed;
   } ctrl_word_t;

   // Build the word published at the end of a poll from the freshly
   // captured button image and the previously published word.
   function automatic ctrl_word_t commit_word(input logic [7:0] shadow,
                                              input ctrl_word_t old);
      ctrl_word_t w;
      w.rsvd    = 8'h00;
      w.seq     = old.seq + 8'd1;           // wraps 255 -> 0 naturally
      w.newly   = shadow & ~old.pressed;    // rising edges of button state
      w.pressed = shadow;
      return w;
   endfunction

endpackage

// File: rtl/controller_poller_if.sv
// Pin and CPU-side signal bundle of the controller poller. The master side
// is the poller itself; the slave side is the board pins plus the CPU
// memory system that consumes controller_data.
interface controller_poller_if;

   logic        en;               // global enable, low freezes the poller
   logic        ctrl_data;        // serial data from controller, active-low
   logic        ctrl_latch;       // latch strobe to controller
   logic        ctrl_pulse;       // shift clock to controller
   logic [31:0] controller_data;  // decoded button word
   logic        update;           // high in the cycle controller_data changes

   modport master (
      input  en,
      input  ctrl_data,
      output ctrl_latch,
      output ctrl_pulse,
      output controller_data,
      output update
   );

   modport slave (
      output en,
      output ctrl_data,
      input  ctrl_latch,
      input  ctrl_pulse,
      input  controller_data,
      input  update
   );

endinterface

// File: rtl/controller_poller_poll_timer.sv
// Per-state cycle timer. Counts cycles spent in the current FSM state and
// raises done on the last one; the count then restarts from zero so the
// next state is timed from its first cycle. The FSM supplies the terminal
// value of whichever state it is in, which is how it reloads the timer.
module poll_timer #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] last,   // terminal count of the current state
   output logic             done
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Advance the count while enabled, restarting after the terminal cycle.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      count_d = count_q;
      done    = (count_q == last);
      if (en) begin
         count_d = done ? '0 : count_q + WIDTH'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

endmodule

// File: rtl/controller_poller.sv
// Autonomous NES-style controller poller. Every poll it latches the pad,
// clocks NUM_BUTTONS serial bits in through a two-flop synchronizer and
// publishes the decoded buttons, newly pressed buttons and a poll count as
// one 32-bit word with a single-cycle update strobe. CLK_DIV must be >= 3 so
// sample points stay clear of the synchronizer delay; POLL_PERIOD >= 1;
// NUM_BUTTONS in 1..8.
module controller_poller
   import controller_poller_pkg::*;
#(
   parameter int CLK_DIV     = 300,
   parameter int POLL_PERIOD = 1000,
   parameter int NUM_BUTTONS = 8
) (
   input  logic                clk,
   input  logic                rst,
   controller_poller_if.master bus
);

   // Timer must hold the longest state length minus one.
   localparam int MAX_LEN = (POLL_PERIOD > 2 * CLK_DIV) ? POLL_PERIOD : 2 * CLK_DIV;
   localparam int TW      = $clog2(MAX_LEN + 1);

   localparam logic [TW-1:0] IDLE_LAST  = TW'(POLL_PERIOD - 1);
   localparam logic [TW-1:0] LATCH_LAST = TW'(2 * CLK_DIV - 1);
   localparam logic [TW-1:0] HALF_LAST  = TW'(CLK_DIV - 1);
   localparam logic [2:0]    LAST_BIT   = 3'(NUM_BUTTONS - 1);

   logic [2:0]  state_q,   state_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shadow_q,  shadow_d;
   logic        sync1_q,   sync1_d;
   logic        sync2_q,   sync2_d;
   logic        latch_q,   latch_d;
   logic        pulse_q,   pulse_d;
   logic        update_q,  update_d;
   ctrl_word_t  word_q,    word_d;

   logic [TW-1:0] timer_last;
   logic          timer_done;

   // Terminal count for the state currently being timed.
   always_comb begin
      timer_last = '0;
      case (state_q)
         ST_IDLE:                            timer_last = IDLE_LAST;
         ST_LATCH:                           timer_last = LATCH_LAST;
         ST_SETTLE, ST_PULSE_HI, ST_PULSE_LO: timer_last = HALF_LAST;
         default:                            timer_last = '0;  // COMMIT is one cycle
      endcase
   end

   poll_timer #(
      .WIDTH (TW)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .en   (bus.en),
      .last (timer_last),
      .done (timer_done)
   );

   // Poll sequencing, bit capture and commit of the published word.
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      shadow_d  = shadow_q;
      sync1_d   = sync1_q;
      sync2_d   = sync2_q;
      word_d    = word_q;
      update_d  = update_q;   // held while disabled, so a strobe stretches

      if (bus.en) begin
         sync1_d  = bus.ctrl_data;
         sync2_d  = sync1_q;
         update_d = 1'b0;

         if (timer_done) begin
            case (state_q)
               ST_IDLE: begin
                  state_d = ST_LATCH;
               end
               ST_LATCH: begin
                  state_d = ST_SETTLE;
               end
               ST_SETTLE: begin
                  // Bit 0 is presented by the pad as soon as it is latched.
                  shadow_d[0] = ~sync2_q;
                  bit_idx_d   = 3'd1;
                  state_d     = (NUM_BUTTONS == 1) ? ST_COMMIT : ST_PULSE_HI;
               end
               ST_PULSE_HI: begin
                  state_d = ST_PULSE_LO;
               end
               ST_PULSE_LO: begin
                  shadow_d[bit_idx_q] = ~sync2_q;
                  if (bit_idx_q == LAST_BIT) begin
                     state_d = ST_COMMIT;
                  end else begin
                     bit_idx_d = bit_idx_q + 3'd1;
                     state_d   = ST_PULSE_HI;
                  end
               end
               ST_COMMIT: begin
                  word_d    = commit_word(shadow_q, word_q);
                  update_d  = 1'b1;
                  bit_idx_d = 3'd0;
                  state_d   = ST_IDLE;
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end
      end
   end

   // Pad strobes are decoded from the next state so they leave a flop
   // aligned with the state they belong to; they can never overlap.
   always_comb begin
      latch_d = (state_d == ST_LATCH);
      pulse_d = (state_d == ST_PULSE_HI);
   end

   // All poller state with synchronous reset; synchronizer idles released.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bit_idx_q <= 3'd0;
         // NOTE: the shadow image is reset explicitly so a poll cut short
         // by reset can never leak partial button bits into a later commit.
         shadow_q  <= 8'h00;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         latch_q   <= 1'b0;
         pulse_q   <= 1'b0;
         update_q  <= 1'b0;
         word_q    <= '0;
      end else begin
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         shadow_q  <= shadow_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         latch_q   <= latch_d;
         pulse_q   <= pulse_d;
         update_q  <= update_d;
         word_q    <= word_d;
      end
   end

   assign bus.ctrl_latch      = latch_q;
   assign bus.ctrl_pulse      = pulse_q;
   assign bus.update          = update_q;
   assign bus.controller_data = word_q;

endmodule

// File: tb/tb_controller_poller.sv
// Bench for controller_poller: a behavioural NES pad answers the latch and
// pulse strobes, a table of button patterns with hand-computed words checks
// the decode rules, hand sequences cover timing, stall and reset corners,
// and a run of random polls is checked against a word-level model.
module tb_controller_poller;

   localparam int CLK_DIV     = 4;
   localparam int POLL_PERIOD = 16;
   localparam int NUM_BUTTONS = 8;
   localparam int POLL_LEN    = 85;
   localparam logic [7:0] BTN_MASK = 8'hFF >> (8 - NUM_BUTTONS);

   logic clk = 1'b0;
   logic rst = 1'b1;

   controller_poller_if bus ();

   controller_poller #(
      .CLK_DIV     (CLK_DIV),
      .POLL_PERIOD (POLL_PERIOD),
      .NUM_BUTTONS (NUM_BUTTONS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Buttons currently held on the pad (1 = pressed).
   logic [7:0] buttons = 8'h00;

   // Word-level reference state: last published pressed image and count.
   logic [7:0] m_prev = 8'h00;
   logic [7:0] m_cnt  = 8'h00;

   typedef struct {
      logic [7:0]  btn;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[8];

   // Behavioural pad: latch reloads the shift register, each pulse rise
   // moves on one bit, output is active-low.
   initial begin : pad_model
      int  k;
      logic prev_p;
      k      = 8;
      prev_p = 1'b0;
      bus.ctrl_data = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bus.ctrl_latch)                    k = 0;
         else if (bus.ctrl_pulse && !prev_p)    k = k + 1;
         prev_p = bus.ctrl_pulse;
         bus.ctrl_data = (k < 8) ? ~buttons[k] : 1'b0;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Expected word of the next poll from the decode rules.
   task automatic model_next(input logic [7:0] btn, output logic [31:0] exp);
      logic [7:0] p;
      p      = btn & BTN_MASK;
      exp    = {8'h00, m_cnt + 8'd1, p & ~m_prev, p};
      m_cnt  = m_cnt + 8'd1;
      m_prev = p;
   endtask

   task automatic wait_update(output int n, output bit got);
      n   = 0;
      got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         step();
         n++;
         if (bus.update === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   // One full poll: hold btn, wait for the strobe, check word, optional
   // period, optional stretched strobe under en=0, then strobe drop.
   task automatic do_poll(input logic [7:0] btn, input logic [31:0] exp,
                          input int gap, input int stretch, input string name);
      int n;
      bit got;
      buttons = btn;
      wait_update(n, got);
      check({name, " strobe"}, {31'd0, got}, 32'd1);
      if (got) begin
         check({name, " word"}, bus.controller_data, exp);
         if (gap != 0) check({name, " period"}, 32'(n), 32'(gap));
         if (stretch != 0) begin
            bus.en = 1'b0;
            for (int i = 0; i < stretch; i++) begin
               step();
               check({name, " held strobe"}, {31'd0, bus.update}, 32'd1);
               check({name, " held word"}, bus.controller_data, exp);
            end
            bus.en = 1'b1;
         end
         step();
         check({name, " strobe drop"}, {31'd0, bus.update}, 32'd0);
      end
   endtask

   initial begin : main
      logic [31:0] e;
      logic [7:0]  b;
      int n, first_latch, lat_hi, pulses, hi_run, lo_run, bad_hi, bad_lo, overlap, hi;
      bit  got, prev_p;

      vecs[0] = '{8'h09, 32'h0002_0909};
      vecs[1] = '{8'h09, 32'h0003_0009};
      vecs[2] = '{8'h88, 32'h0004_8088};
      vecs[3] = '{8'hFF, 32'h0005_77FF};
      vecs[4] = '{8'h00, 32'h0006_0000};
      vecs[5] = '{8'hA5, 32'h0007_A5A5};
      vecs[6] = '{8'h5A, 32'h0008_5A5A};
      vecs[7] = '{8'h5B, 32'h0009_015B};

      bus.en = 1'b1;
      rst    = 1'b1;
      repeat (3) step();
      check("reset strobes", {29'd0, bus.update, bus.ctrl_pulse, bus.ctrl_latch}, 32'd0);
      check("reset word", bus.controller_data, 32'd0);

      // First poll after reset: latch at 16, 8 wide, seven 4/4 pulses,
      // strobe at 85 with count 1 and no buttons.
      rst = 1'b0;
      n = 0; first_latch = 0; lat_hi = 0; pulses = 0; hi_run = 0; lo_run = 0;
      bad_hi = 0; bad_lo = 0; overlap = 0; got = 1'b0; prev_p = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step();
         n++;
         if (bus.ctrl_latch && first_latch == 0) first_latch = n;
         if (bus.ctrl_latch) lat_hi++;
         if (bus.ctrl_latch && bus.ctrl_pulse) overlap++;
         if (bus.ctrl_pulse) begin
            if (!prev_p) begin
               pulses++;
               if (pulses > 1 && lo_run != CLK_DIV) bad_lo++;
            end
            hi_run++;
         end else begin
            if (prev_p) begin
               if (hi_run != CLK_DIV) bad_hi++;
               hi_run = 0;
               lo_run = 0;
            end
            lo_run++;
         end
         prev_p = bus.ctrl_pulse;
         if (bus.update) begin
            got = 1'b1;
            break;
         end
      end
      check("latch delay", 32'(first_latch), 32'(POLL_PERIOD));
      check("latch width", 32'(lat_hi), 32'(2 * CLK_DIV));
      check("pulse count", 32'(pulses), 32'(NUM_BUTTONS - 1));
      check("pulse high width", 32'(bad_hi), 32'd0);
      check("pulse low width", 32'(bad_lo), 32'd0);
      check("latch/pulse overlap", 32'(overlap), 32'd0);
      check("first strobe", {31'd0, got}, 32'd1);
      check("first period", 32'(n), 32'(POLL_LEN));
      check("first word", bus.controller_data, 32'h0001_0000);
      model_next(8'h00, e);
      step();
      check("first strobe drop", {31'd0, bus.update}, 32'd0);

      // Table of button patterns with hand-computed words.
      for (int i = 0; i < 8; i++) begin
         model_next(vecs[i].btn, e);
         do_poll(vecs[i].btn, vecs[i].exp, POLL_LEN - 1, 0, $sformatf("vec%0d", i));
      end

      // Freeze for 10 cycles in the middle of the pulse that precedes bit 4.
      buttons = 8'h3C;
      model_next(8'h3C, e);
      pulses = 0; prev_p = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (bus.ctrl_pulse && !prev_p) pulses++;
         prev_p = bus.ctrl_pulse;
         if (pulses == 4) break;
      end
      check("stall reach pulse 4", 32'(pulses), 32'd4);
      hi = 1;
      step();
      hi += int'(bus.ctrl_pulse);
      bus.en = 1'b0;
      repeat (10) begin
         step();
         hi += int'(bus.ctrl_pulse);
      end
      bus.en = 1'b1;
      for (int i = 0; i < 30; i++) begin
         step();
         if (bus.ctrl_pulse) hi++;
         else break;
      end
      check("stalled pulse width", 32'(hi), 32'(CLK_DIV + 10));
      do_poll(8'h3C, e, 0, 0, "stall");

      // Strobe held across a disabled stretch is not lost.
      model_next(8'h42, e);
      do_poll(8'h42, e, POLL_LEN - 1, 3, "stretch");
      model_next(8'h43, e);
      do_poll(8'h43, e, POLL_LEN - 1, 0, "after stretch");

      // Reset while the pad clock is high.
      buttons = 8'hF0;
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (bus.ctrl_pulse) begin
            got = 1'b1;
            break;
         end
      end
      check("reach pulse for reset", {31'd0, got}, 32'd1);
      rst = 1'b1;
      step();
      check("mid reset strobes", {29'd0, bus.update, bus.ctrl_pulse, bus.ctrl_latch}, 32'd0);
      check("mid reset word", bus.controller_data, 32'd0);
      rst     = 1'b0;
      m_prev  = 8'h00;
      m_cnt   = 8'h00;
      buttons = 8'h81;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         n++;
         if (bus.ctrl_latch) break;
      end
      check("latch after reset", 32'(n), 32'(POLL_PERIOD));
      model_next(8'h81, e);
      do_poll(8'h81, e, 0, 0, "post reset");

      // 256 random polls: count wraps, one strobe per poll period.
      for (int i = 0; i < 256; i++) begin
         b = 8'($urandom);
         model_next(b, e);
         do_poll(b, e, POLL_LEN - 1, 0, $sformatf("rand%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
